// File: rtl/traffic_pkg.sv
// Shared types, lamp patterns and digit helpers for the two-way junction controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_CLR, S_MG, S_MY, S_SG, S_SY, S_HOLD_M, S_HOLD_S, S_NIGHT
    } state_t;

    typedef enum logic [1:0] {
        M_NIGHT  = 2'b00,
        M_NORMAL = 2'b01,
        M_HOLD_M = 2'b10,
        M_HOLD_S = 2'b11
    } mode_t;

    // Lamp bus: [7]mainR [6]mainY [5]mainG [2]sideR [1]sideY [0]sideG
    localparam logic [7:0] LAMP_MG     = 8'h24;
    localparam logic [7:0] LAMP_MY     = 8'h44;
    localparam logic [7:0] LAMP_MY_OFF = 8'h04;
    localparam logic [7:0] LAMP_SG     = 8'h81;
    localparam logic [7:0] LAMP_SY     = 8'h82;
    localparam logic [7:0] LAMP_SY_OFF = 8'h80;
    localparam logic [7:0] LAMP_CLR    = 8'h84;
    localparam logic [7:0] LAMP_NIGHT  = 8'h42;
    localparam logic [7:0] LAMP_OFF    = 8'h00;

    localparam logic [3:0] CODE_D     = 4'hD;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    function automatic logic [7:0] seg_lut(input logic [3:0] code);
        case (code)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            CODE_D:  return 8'h5E;
            default: return 8'h00;
        endcase
    endfunction

    // Returns {tens, ones} for v in 0..99; ones is formed modulo 16 from the low nibble.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        t = '0;
        for (int unsigned i = 1; i < 10; i++) begin
            if (v >= 7'(i * 10)) t = 4'(i);
        end
        return {t, v[3:0] - t * 4'd10};
    endfunction

endpackage

// File: rtl/seg_scan4.sv
// Four-digit multiplexed 7-segment driver: rotating one-hot enable with matching segment pattern.
module seg_scan4
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code0,
    input  logic [3:0] code1,
    input  logic [3:0] code2,
    input  logic [3:0] code3,
    output logic [3:0] scan,
    output logic [7:0] dout
);

    logic [1:0] sel;
    logic [1:0] sel_n;
    logic [3:0] code_n;

    assign sel_n = sel + 2'd1;

    always_comb begin
        code_n = code0;
        case (sel_n)
            2'd0: code_n = code0;
            2'd1: code_n = code1;
            2'd2: code_n = code2;
            2'd3: code_n = code3;
            default: code_n = code0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel  <= '0;
            scan <= 4'b0001;
            dout <= '0;
        end else begin
            sel  <= sel_n;
            scan <= 4'b0001 << sel_n;
            dout <= seg_lut(code_n);
        end
    end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Main/side junction controller: 1 s prescaler, mode synchroniser, phase FSM and countdown display.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 1000,
    parameter int unsigned MAIN_GREEN = 30,
    parameter int unsigned SIDE_GREEN = 20,
    parameter int unsigned YELLOW     = 4,
    parameter int unsigned ALL_RED    = 1
) (
    input  logic       clk1khz,
    input  logic       rst,
    input  logic [1:0] mode,
    output logic [7:0] light,
    output logic [7:0] dout,
    output logic [3:0] scan
);

    localparam int unsigned PW   = $clog2(CLK_HZ);
    localparam logic [6:0]  MG_T = 7'(MAIN_GREEN);
    localparam logic [6:0]  SG_T = 7'(SIDE_GREEN);
    localparam logic [6:0]  YEL  = 7'(YELLOW);
    localparam logic [6:0]  AR_T = 7'(ALL_RED);

    logic [PW-1:0] pre;
    logic          tick;
    mode_t         m1, m2;
    state_t        state, state_n, next_go, go_n, go_sel;
    logic [6:0]    sec_cnt, sec_n;
    logic          to_clr;

    assign tick = (pre == PW'(CLK_HZ - 1));

    always_ff @(posedge clk1khz) begin
        if (!rst) begin
            pre     <= '0;
            m1      <= M_NORMAL;
            m2      <= M_NORMAL;
            state   <= S_CLR;
            sec_cnt <= AR_T;
            next_go <= S_MG;
        end else begin
            pre     <= tick ? '0 : pre + PW'(1);
            m1      <= mode_t'(mode);
            m2      <= m1;
            state   <= state_n;
            sec_cnt <= sec_n;
            next_go <= go_n;
        end
    end

    // The mode seen at clearance exit overrides the stored green target.
    function automatic state_t clr_exit(input mode_t m, input state_t go);
        case (m)
            M_NIGHT:  return S_NIGHT;
            M_HOLD_M: return S_HOLD_M;
            M_HOLD_S: return S_HOLD_S;
            default:  return go;
        endcase
    endfunction

    function automatic logic [6:0] load_for(input state_t s);
        case (s)
            S_MG:    return MG_T;
            S_SG:    return SG_T;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        sec_n   = sec_cnt;
        go_n    = next_go;
        to_clr  = 1'b0;
        go_sel  = next_go;
        if (tick) begin
            case (state)
                S_CLR: begin
                    if (sec_cnt <= 7'd1) begin
                        state_n = clr_exit(m2, next_go);
                        sec_n   = load_for(state_n);
                    end else begin
                        sec_n = sec_cnt - 7'd1;
                    end
                end
                S_MG: begin
                    if (m2 == M_HOLD_M) state_n = S_HOLD_M;
                    else if (m2 != M_NORMAL || sec_cnt - 7'd1 == YEL) begin
                        state_n = S_MY;
                        sec_n   = YEL;
                    end else sec_n = sec_cnt - 7'd1;
                end
                S_MY: begin
                    if (m2 == M_HOLD_M) state_n = S_HOLD_M;
                    else if (sec_cnt <= 7'd1) begin
                        to_clr = 1'b1;
                        go_sel = S_SG;
                    end else sec_n = sec_cnt - 7'd1;
                end
                S_SG: begin
                    if (m2 == M_HOLD_S) state_n = S_HOLD_S;
                    else if (m2 != M_NORMAL || sec_cnt - 7'd1 == YEL) begin
                        state_n = S_SY;
                        sec_n   = YEL;
                    end else sec_n = sec_cnt - 7'd1;
                end
                S_SY: begin
                    if (m2 == M_HOLD_S) state_n = S_HOLD_S;
                    else if (sec_cnt <= 7'd1) begin
                        to_clr = 1'b1;
                        go_sel = S_MG;
                    end else sec_n = sec_cnt - 7'd1;
                end
                S_HOLD_M: begin
                    if (m2 != M_HOLD_M) begin
                        state_n = S_MY;
                        sec_n   = YEL;
                    end
                end
                S_HOLD_S: begin
                    if (m2 != M_HOLD_S) begin
                        state_n = S_SY;
                        sec_n   = YEL;
                    end
                end
                S_NIGHT: begin
                    if (m2 == M_NIGHT) sec_n = sec_cnt ^ 7'd1;
                    else begin
                        to_clr = 1'b1;
                        go_sel = S_MG;
                    end
                end
                default: state_n = S_CLR;
            endcase
            // Zero-length clearance resolves its exit in the same tick.
            if (to_clr) begin
                go_n = go_sel;
                if (ALL_RED == 0) begin
                    state_n = clr_exit(m2, go_sel);
                    sec_n   = load_for(state_n);
                end else begin
                    state_n = S_CLR;
                    sec_n   = AR_T;
                end
            end
        end
    end

    always_comb begin
        light = LAMP_CLR;
        case (state)
            S_MG, S_HOLD_M: light = LAMP_MG;
            S_MY:           light = sec_cnt[0] ? LAMP_MY : LAMP_MY_OFF;
            S_SG, S_HOLD_S: light = LAMP_SG;
            S_SY:           light = sec_cnt[0] ? LAMP_SY : LAMP_SY_OFF;
            S_NIGHT:        light = sec_cnt[0] ? LAMP_OFF : LAMP_NIGHT;
            default:        light = LAMP_CLR;
        endcase
    end

    logic [7:0] red_sum, go_bcd, red_bcd;
    logic [6:0] red_val;
    logic [3:0] c0, c1, c2, c3;

    assign red_sum = {1'b0, sec_cnt} + 8'(ALL_RED);
    assign red_val = (red_sum > 8'd99) ? 7'd99 : red_sum[6:0];
    assign go_bcd  = to_bcd(sec_cnt);
    assign red_bcd = to_bcd(red_val);

    always_comb begin
        {c3, c2, c1, c0} = {4{CODE_BLANK}};
        case (state)
            S_MG, S_MY:         {c3, c2, c1, c0} = {red_bcd, go_bcd};
            S_SG, S_SY:         {c3, c2, c1, c0} = {go_bcd, red_bcd};
            S_HOLD_M, S_HOLD_S: {c3, c2, c1, c0} = {4{CODE_D}};
            default:            {c3, c2, c1, c0} = {4{CODE_BLANK}};
        endcase
    end

    seg_scan4 u_scan (
        .clk   (clk1khz),
        .rst   (rst),
        .code0 (c0),
        .code1 (c1),
        .code2 (c2),
        .code3 (c3),
        .scan  (scan),
        .dout  (dout)
    );

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Scoreboard bench for traffic_ctrl_param: expected lamps and digits queued per tick, checked after it.
module tb_traffic_ctrl_param;

    logic       clk1khz = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] light;
    logic [7:0] dout;
    logic [3:0] scan;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_ctrl_param #(
        .CLK_HZ     (8),
        .MAIN_GREEN (6),
        .SIDE_GREEN (5),
        .YELLOW     (2),
        .ALL_RED    (1)
    ) dut (
        .clk1khz (clk1khz),
        .rst     (rst),
        .mode    (mode),
        .light   (light),
        .dout    (dout),
        .scan    (scan)
    );

    always #5 clk1khz = ~clk1khz;

    typedef struct {
        string           tag;
        logic [7:0]      light;
        logic [3:0][7:0] dig;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seg7(input int unsigned d);
        case (d)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    // Go direction shows v; the red direction shows v plus one second of clearance.
    task automatic push_go(input string tag, input logic [7:0] lt, input bit main_go, input int unsigned v);
        exp_t e;
        int unsigned r;
        r = (v + 1 > 99) ? 99 : v + 1;
        e.tag   = tag;
        e.light = lt;
        if (main_go) begin
            e.dig[0] = seg7(v % 10); e.dig[1] = seg7(v / 10);
            e.dig[2] = seg7(r % 10); e.dig[3] = seg7(r / 10);
        end else begin
            e.dig[2] = seg7(v % 10); e.dig[3] = seg7(v / 10);
            e.dig[0] = seg7(r % 10); e.dig[1] = seg7(r / 10);
        end
        sb.push_back(e);
    endtask

    task automatic push_fill(input string tag, input logic [7:0] lt, input logic [7:0] pat);
        exp_t e;
        e.tag   = tag;
        e.light = lt;
        for (int k = 0; k < 4; k++) e.dig[k] = pat;
        sb.push_back(e);
    endtask

    // Called 4 cycles after the previous tick: lands on the next tick, then watches 4 scan slots.
    task automatic tick_check();
        exp_t e;
        logic [3:0] es;
        int idx;
        repeat (4) @(posedge clk1khz);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_light"}, 32'(light), 32'(e.light));
            for (int k = 0; k < 4; k++) begin
                @(posedge clk1khz);
                #1;
                idx = (k + 1) % 4;
                es  = 4'(1 << idx);
                chk({e.tag, "_scan"}, 32'(scan), 32'(es));
                chk({e.tag, "_dig"}, 32'(dout), 32'(e.dig[idx]));
            end
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick_check();
    endtask

    task automatic reset_seq();
        rst = 1'b0;
        @(posedge clk1khz);
        #1;
        chk("rst_light", 32'(light), 32'h84);
        chk("rst_scan", 32'(scan), 32'b0001);
        chk("rst_dout", 32'(dout), 32'h00);
        repeat (2) @(posedge clk1khz);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk1khz);
    endtask

    initial begin
        rst  = 1'b0;
        mode = 2'b01;
        repeat (2) @(posedge clk1khz);
        reset_seq();

        // Normal cycle, one full 13-tick period plus the return to MG
        push_go("mg6", 8'h24, 1, 6);   push_go("mg5", 8'h24, 1, 5);
        push_go("mg4", 8'h24, 1, 4);   push_go("mg3", 8'h24, 1, 3);
        push_go("my2", 8'h04, 1, 2);   push_go("my1", 8'h44, 1, 1);
        push_fill("clr_a", 8'h84, 8'h00);
        push_go("sg5", 8'h81, 0, 5);   push_go("sg4", 8'h81, 0, 4);
        push_go("sg3", 8'h81, 0, 3);
        push_go("sy2", 8'h80, 0, 2);   push_go("sy1", 8'h82, 0, 1);
        push_fill("clr_b", 8'h84, 8'h00);
        push_go("mg6_b", 8'h24, 1, 6);
        run_ticks(14);

        // Side hold requested while main is green
        mode = 2'b11;
        push_go("hs_my2", 8'h04, 1, 2); push_go("hs_my1", 8'h44, 1, 1);
        push_fill("hs_clr", 8'h84, 8'h00);
        push_fill("hold_s", 8'h81, 8'h5E); push_fill("hold_s2", 8'h81, 8'h5E);
        run_ticks(5);

        // Release hold: side yellow, clearance, full main green
        mode = 2'b01;
        push_go("rl_sy2", 8'h80, 0, 2); push_go("rl_sy1", 8'h82, 0, 1);
        push_fill("rl_clr", 8'h84, 8'h00);
        push_go("rl_mg6", 8'h24, 1, 6); push_go("rl_mg5", 8'h24, 1, 5);
        push_go("rl_mg4", 8'h24, 1, 4); push_go("rl_mg3", 8'h24, 1, 3);
        push_go("rl_my2", 8'h04, 1, 2); push_go("rl_my1", 8'h44, 1, 1);
        push_fill("rl_clr2", 8'h84, 8'h00);
        push_go("rl_sg5", 8'h81, 0, 5);
        run_ticks(11);

        // Night request during side green
        mode = 2'b00;
        push_go("nt_sy2", 8'h80, 0, 2); push_go("nt_sy1", 8'h82, 0, 1);
        push_fill("nt_clr", 8'h84, 8'h00);
        push_fill("night0", 8'h42, 8'h00); push_fill("night1", 8'h00, 8'h00);
        push_fill("night2", 8'h42, 8'h00);
        run_ticks(6);

        mode = 2'b01;
        push_fill("nx_clr", 8'h84, 8'h00);
        push_go("nx_mg6", 8'h24, 1, 6);
        run_ticks(2);

        // Main hold while main green enters hold directly
        mode = 2'b10;
        push_fill("hold_m", 8'h24, 8'h5E); push_fill("hold_m2", 8'h24, 8'h5E);
        run_ticks(2);

        mode = 2'b01;
        push_go("hm_my2", 8'h04, 1, 2); push_go("hm_my1", 8'h44, 1, 1);
        push_fill("hm_clr", 8'h84, 8'h00);
        push_go("hm_sg5", 8'h81, 0, 5); push_go("hm_sg4", 8'h81, 0, 4);
        push_go("hm_sg3", 8'h81, 0, 3); push_go("hm_sy2", 8'h80, 0, 2);
        run_ticks(7);

        // Reset in the middle of side yellow restarts from clearance
        reset_seq();
        push_go("rs_mg6", 8'h24, 1, 6); push_go("rs_mg5", 8'h24, 1, 5);
        run_ticks(2);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
